// File: rtl/m_parity_rx_if.sv
// Handshake/bus bundle for the bit-serial parity receiver.
// The link side drives the master modport and the receiver uses the slave modport.
interface m_parity_rx_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             i_start;
    logic             i_bit;
    logic             i_bit_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             o_parity_err;
    logic             o_busy;
    logic             o_abort;

    modport master (
        output i_start,
        output i_bit,
        output i_bit_valid,
        input  o_data,
        input  o_valid,
        input  o_parity_err,
        input  o_busy,
        input  o_abort
    );

    modport slave (
        input  i_start,
        input  i_bit,
        input  i_bit_valid,
        output o_data,
        output o_valid,
        output o_parity_err,
        output o_busy,
        output o_abort
    );
endinterface

// File: rtl/m_parity_rx.sv
// Bit-serial word receiver: shifts in WIDTH data bits LSB first plus one parity bit,
// then presents the word with a parity-error flag and a one-cycle valid strobe.
module m_parity_rx #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    m_parity_rx_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic ACC_INIT = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              acc_q, acc_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              abort_q, abort_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        data_d  = data_q;
        err_d   = err_q;
        valid_d = 1'b0;
        abort_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    shift_d = '0;
                    acc_d   = ACC_INIT;
                end
            end
            S_DATA, S_PARITY: begin
                // A start mid-frame wins over any bit presented in the same cycle.
                if (bus.i_start) begin
                    abort_d = 1'b1;
                    state_d = S_DATA;
                    cnt_d   = '0;
                    shift_d = '0;
                    acc_d   = ACC_INIT;
                end else if (bus.i_bit_valid) begin
                    if (state_q == S_DATA) begin
                        shift_d[cnt_q] = bus.i_bit;
                        acc_d          = acc_q ^ bus.i_bit;
                        if (cnt_q == LAST_IDX) begin
                            state_d = S_PARITY;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        data_d  = shift_q;
                        err_d   = acc_q ^ bus.i_bit;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_parity_err = err_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_abort      = abort_q;
endmodule

// File: tb/tb_m_parity_rx.sv
// Scoreboard bench: even-parity (dut0) and odd-parity (dut1) receivers driven with
// directed and random frames; monitors compare every o_valid against a queue.
module tb_m_parity_rx;
    logic clk = 1'b0;
    logic rst_n;
    logic st [2];
    logic bt [2];
    logic bv [2];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    logic [15:0] last_data [2];
    int          abort_seen [2];
    int          abort_exp  [2];

    always #5 clk = ~clk;

    m_parity_rx_if #(.WIDTH(16)) e0 ();
    m_parity_rx_if #(.WIDTH(16)) e1 ();

    assign e0.i_start     = st[0];
    assign e0.i_bit       = bt[0];
    assign e0.i_bit_valid = bv[0];
    assign e1.i_start     = st[1];
    assign e1.i_bit       = bt[1];
    assign e1.i_bit_valid = bv[1];

    m_parity_rx #(.WIDTH(16), .PARITY_ODD(0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(e0));
    m_parity_rx #(.WIDTH(16), .PARITY_ODD(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(e1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference rule: total ones over data+parity must be even (or odd when odd parity).
    function automatic logic model_err(input logic [15:0] w, input logic p, input int odd);
        int total;
        total = $countones(w) + int'(p);
        return ((total + odd) % 2) == 1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int idx);
        st[idx] = 1'b1;
        bv[idx] = 1'b1;   // must be ignored in the start cycle
        bt[idx] = 1'b1;
        cyc();
        st[idx] = 1'b0;
        bv[idx] = 1'b0;
    endtask

    task automatic send_bits(input int idx, input logic [15:0] w, input int from, input int to,
                             input int maxgap);
        for (int i = from; i < to; i++) begin
            int g;
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                bv[idx] = 1'b0;
                bt[idx] = 1'($urandom);
                cyc();
            end
            bv[idx] = 1'b1;
            bt[idx] = w[i];
            cyc();
            bv[idx] = 1'b0;
        end
    endtask

    task automatic send_parity(input int idx, input logic [15:0] w, input logic p, input int maxgap);
        exp_t e;
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        for (int k = 0; k < g; k++) begin
            bv[idx] = 1'b0;
            cyc();
        end
        e.data = w;
        e.err  = model_err(w, p, idx);
        if (idx == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
        last_data[idx] = w;
        bv[idx] = 1'b1;
        bt[idx] = p;
        cyc();
        bv[idx] = 1'b0;
    endtask

    task automatic frame(input int idx, input logic [15:0] w, input logic p, input int maxgap);
        start_frame(idx);
        send_bits(idx, w, 0, 16, maxgap);
        send_parity(idx, w, p, maxgap);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (e0.o_abort === 1'b1) abort_seen[0]++;
            if (e1.o_abort === 1'b1) abort_seen[1]++;
            if (e0.o_valid === 1'b1) begin
                if (exp_q0.size() == 0) begin
                    chk("dut0_spurious_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q0.pop_front();
                    chk("dut0_data", 32'(e0.o_data), 32'(e.data));
                    chk("dut0_err", 32'(e0.o_parity_err), 32'(e.err));
                end
            end
            if (e1.o_valid === 1'b1) begin
                if (exp_q1.size() == 0) begin
                    chk("dut1_spurious_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q1.pop_front();
                    chk("dut1_data", 32'(e1.o_data), 32'(e.data));
                    chk("dut1_err", 32'(e1.o_parity_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; bt[i] = 1'b0; bv[i] = 1'b0;
            last_data[i] = '0; abort_seen[i] = 0; abort_exp[i] = 0;
        end
        rst_n = 1'b0;
        cyc(); cyc();
        chk("rst_data", 32'(e0.o_data), 0);
        chk("rst_valid", 32'(e0.o_valid), 0);
        chk("rst_err", 32'(e0.o_parity_err), 0);
        chk("rst_busy", 32'(e0.o_busy), 0);
        chk("rst_abort", 32'(e0.o_abort), 0);
        rst_n = 1'b1;
        cyc();

        // 0xA5A5 even parity, with latency and busy timing checks
        start_frame(0);
        chk("busy_in_frame", 32'(e0.o_busy), 1);
        send_bits(0, 16'hA5A5, 0, 16, 0);
        chk("busy_in_parity", 32'(e0.o_busy), 1);
        send_parity(0, 16'hA5A5, 1'b0, 0);
        chk("valid_latency", 32'(e0.o_valid), 1);
        chk("busy_drop", 32'(e0.o_busy), 0);
        chk("data_a5a5", 32'(e0.o_data), 32'h A5A5);
        cyc();
        chk("valid_one_cycle", 32'(e0.o_valid), 0);
        chk("data_held", 32'(e0.o_data), 32'h A5A5);

        frame(0, 16'hA5A5, 1'b1, 0);
        cyc();
        frame(0, 16'h0001, 1'b1, 0);
        cyc();
        frame(0, 16'hFFFF, 1'b0, 0);
        cyc();

        // stray valid bits while idle, then a gappy frame
        for (int k = 0; k < 4; k++) begin
            bv[0] = 1'b1; bt[0] = 1'($urandom);
            cyc();
        end
        bv[0] = 1'b0;
        cyc();
        chk("idle_no_valid", 32'(e0.o_valid), 0);
        chk("idle_data_hold", 32'(e0.o_data), 32'h FFFF);
        chk("idle_busy", 32'(e0.o_busy), 0);
        frame(0, 16'h1234, 1'b1, 3);
        cyc();

        // restart after 7 bits
        start_frame(0);
        send_bits(0, 16'h0055, 0, 7, 0);
        st[0] = 1'b1; bv[0] = 1'b1; bt[0] = 1'b1;
        abort_exp[0]++;
        cyc();
        st[0] = 1'b0; bv[0] = 1'b0;
        chk("abort_pulse", 32'(e0.o_abort), 1);
        chk("abort_data_kept", 32'(e0.o_data), 32'h 1234);
        chk("abort_busy", 32'(e0.o_busy), 1);
        cyc();
        chk("abort_one_cycle", 32'(e0.o_abort), 0);
        send_bits(0, 16'h00FF, 0, 16, 0);
        send_parity(0, 16'h00FF, 1'b0, 0);
        cyc();

        // reset in the middle of a frame
        start_frame(0);
        send_bits(0, 16'hC3C3, 0, 10, 0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        last_data[0] = '0; last_data[1] = '0;
        chk("mrst_data", 32'(e0.o_data), 0);
        chk("mrst_err", 32'(e0.o_parity_err), 0);
        chk("mrst_busy", 32'(e0.o_busy), 0);
        chk("mrst_abort", 32'(e0.o_abort), 0);
        send_bits(0, 16'hC3C3, 10, 16, 0);
        bv[0] = 1'b1; bt[0] = 1'b0;
        cyc();
        bv[0] = 1'b0;
        chk("mrst_no_valid", 32'(e0.o_valid), 0);
        chk("mrst_idle", 32'(e0.o_busy), 0);
        cyc();

        // back-to-back frames: second start lands in the o_valid cycle
        frame(0, 16'hBEEF, 1'b1, 0);
        frame(0, 16'h8000, 1'b1, 0);
        cyc(); cyc();

        // odd parity instance
        frame(1, 16'h8000, 1'b0, 0);
        frame(1, 16'h8000, 1'b1, 1);
        cyc();

        // random frames, randomly back-to-back
        for (int n = 0; n < 30; n++) begin
            int idx;
            idx = int'($urandom_range(1, 0));
            frame(idx, 16'($urandom), 1'($urandom), int'($urandom_range(2, 0)));
            if ($urandom_range(1, 0) == 1) cyc();
        end
        cyc(); cyc(); cyc();

        chk("q0_drained", exp_q0.size(), 0);
        chk("q1_drained", exp_q1.size(), 0);
        chk("abort_count0", abort_seen[0], abort_exp[0]);
        chk("abort_count1", abort_seen[1], abort_exp[1]);
        chk("final_data0", 32'(e0.o_data), 32'(last_data[0]));
        chk("final_data1", 32'(e1.o_data), 32'(last_data[1]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/m_parity_rx.md
Name: m_parity_rx

Overview:
- Bit-serial word receiver with parity checking: the checking end of the XOR parity link.
- Deserialises one WIDTH-bit data word, LSB first, followed by one parity bit.
- Accumulates XOR parity over the data bits, presents the received word with a parity-error flag, and pulses a valid strobe.
- Sits between a serial link (or test header) and the 16-bit datapath/register file input of the CPU.

Parameters:
WIDTH, 16, number of data bits per frame (2..32)
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
i_clk  input  1  system clock; all state changes on rising edge
i_rst_n  input  1  synchronous active-low reset, sampled on rising edge of i_clk
i_start  input  1  frame start strobe; one cycle
i_bit  input  1  serial data/parity bit
i_bit_valid  input  1  i_bit is valid this cycle
o_data  output  WIDTH  last completed word; held until next completion
o_valid  output  1  one-cycle pulse: o_data/o_parity_err updated
o_parity_err  output  1  1 = parity mismatch on last completed frame; held
o_busy  output  1  1 while a frame is in progress (DATA or PARITY state)
o_abort  output  1  one-cycle pulse: in-progress frame discarded by restart

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - state=IDLE; bit counter, shift register and parity accumulator cleared.
  - o_data=0, o_valid=0, o_parity_err=0, o_busy=0, o_abort=0.
  - Reset overrides all other inputs, including mid-frame; a partial frame is discarded with no o_abort.
- States: IDLE, DATA, PARITY.
- IDLE:
  - i_start=1 -> DATA; counter=0, shift=0, acc=PARITY_ODD.
  - i_bit_valid is ignored in IDLE and in the start cycle.
- DATA:
  - Each cycle with i_bit_valid=1: shift[counter]<=i_bit, acc<=acc^i_bit, counter++.
  - When the bit with counter==WIDTH-1 is taken -> PARITY.
  - Cycles with i_bit_valid=0 hold all state; gaps are unlimited, with no timeout.
- PARITY:
  - On i_bit_valid=1: o_data<=shift, o_parity_err<=acc^i_bit, o_valid=1 for exactly the next cycle -> IDLE.
  - With PARITY_ODD=0, err=0 when total ones (data+parity) is even.
- Latency: o_valid and the new o_data/o_parity_err are visible in the cycle after the parity bit is sampled.
- o_busy=1 in DATA and PARITY; it is registered and follows state, so it drops in the same cycle o_valid rises.
- Restart: i_start=1 while in DATA or PARITY:
  - Abandon the frame, pulse o_abort for one cycle, re-initialise counter/shift/acc, stay in/enter DATA.
  - o_data and o_parity_err are unchanged; i_bit_valid is ignored in that cycle.
- i_start=1 in the cycle o_valid is high (state IDLE) is a normal start; back-to-back frames have zero idle cycles.
- o_data/o_parity_err change only on completion or reset.
- The counter is wide enough for WIDTH-1 and never wraps; extra valid bits arriving in IDLE are dropped.

Test Plan:
- Reset, then WIDTH=16 even: start, bits of 0xA5A5 LSB-first, parity 0 -> o_valid pulse 1 cycle after the parity bit; o_data=0xA5A5, o_parity_err=0, o_busy low.
- Same word with parity bit 1 -> o_data=0xA5A5, o_parity_err=1; also 0x0001 with parity 1 -> err=0, and 0xFFFF with parity 0 -> err=0.
- 0x1234 with random 0-3 cycle gaps on i_bit_valid and valid pulses in IDLE before start -> o_data=0x1234, err=0; no spurious o_valid.
- Start, 7 bits, then i_start again -> o_abort pulse, o_data keeps its prior value; then full frame 0x00FF, parity 0 -> o_data=0x00FF, err=0.
- Mid-frame i_rst_n=0 for 1 cycle after 10 bits -> all outputs 0, IDLE; remaining bits ignored until next start.
- Two frames back-to-back (start in o_valid cycle): 0xBEEF/p=1, then 0x8000/p=1 -> two o_valid pulses; err=0 for both (PARITY_ODD=0). Rerun with PARITY_ODD=1 and 0x8000/p=0 -> err=0.
